// File: rtl/fetch_line_responder.sv
// fetch_line_responder: serves 32-bit word reads for the instruction fetch path
// from a single 256-bit line buffer. A miss fetches the aligned line from burst
// memory as four 64-bit beats and then responds.
//
// Handshakes: a request transfers on a clock edge where req_valid && req_ready.
// resp_valid is a one-cycle pulse with no back-pressure. mem_read/mem_addr are
// held until the edge where mem_ready is high. Read beats are taken on any edge
// with mem_rvalid high while the block is in FILL_WAIT.
//
// Optional macro CRITICAL_WORD_FIRST_EN: the response is given from the beat
// holding the requested word, and the block returns straight to IDLE after the
// last beat with no second response.
module fetch_line_responder #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 64,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [BEAT_W-1:0] mem_rdata
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int TAG_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RESP      = 2'd1,
      S_FILL_REQ  = 2'd2,
      S_FILL_WAIT = 2'd3
   } state_t;

   // state_q is the FSM state that checkers bind to.
   state_t              state_q, state_d;
   logic [ADDR_W-1:2]   addr_q, addr_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                line_valid_q, line_valid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                pend_inv_q, pend_inv_d;
   logic                cwf_q, cwf_d;
   logic                req_hit;
   logic                unused_addr_bits;

   // Byte lanes inside a word are irrelevant to a word fetch.
   assign unused_addr_bits = ^req_addr[1:0];

   assign req_hit = line_valid_q && (tag_q == req_addr[ADDR_W-1:OFF_W]) && !flush;

   // Register bank for FSM state, latched request, line buffer and its tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         tag_q        <= '0;
         line_valid_q <= 1'b0;
         cnt_q        <= '0;
         line_q       <= '0;
         pend_inv_q   <= 1'b0;
         cwf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         tag_q        <= tag_d;
         line_valid_q <= line_valid_d;
         cnt_q        <= cnt_d;
         line_q       <= line_d;
         pend_inv_q   <= pend_inv_d;
         cwf_q        <= cwf_d;
      end
   end

   // Next-state, buffer fill and memory-side outputs.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      tag_d        = tag_q;
      line_valid_d = line_valid_q;
      cnt_d        = cnt_q;
      line_d       = line_q;
      pend_inv_d   = pend_inv_q;
      cwf_d        = 1'b0;
      req_ready    = 1'b0;
      mem_read     = 1'b0;
      mem_addr     = '0;
      case (state_q)
         S_IDLE: begin
            // Held low while reset is asserted so nothing is offered then.
            req_ready = !rst;
            if (flush) line_valid_d = 1'b0;
            if (req_valid) begin
               addr_d  = req_addr[ADDR_W-1:2];
               state_d = req_hit ? S_RESP : S_FILL_REQ;
            end
         end
         S_RESP: begin
            // A flush seen during the fill or now drops the line on return to IDLE.
            if (flush || pend_inv_q) line_valid_d = 1'b0;
            pend_inv_d = 1'b0;
            state_d    = S_IDLE;
         end
         S_FILL_REQ: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (flush) pend_inv_d = 1'b1;
            // A beat in the acceptance cycle cannot belong to this burst.
            if (mem_ready) begin
               cnt_d   = '0;
               state_d = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (flush) pend_inv_d = 1'b1;
            if (mem_rvalid) begin
               line_d[cnt_q*BEAT_W +: BEAT_W] = mem_rdata;
               cnt_d = cnt_q + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
               if (cnt_q == addr_q[OFF_W-1 -: CNT_W]) cwf_d = 1'b1;
`endif
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  line_valid_d = 1'b1;
                  tag_d        = addr_q[ADDR_W-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
                  // Response already issued from the critical beat.
                  if (flush || pend_inv_q) line_valid_d = 1'b0;
                  pend_inv_d = 1'b0;
                  state_d    = S_IDLE;
`else
                  state_d    = S_RESP;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Response pulse and word select; the data bus reads zero when idle.
   always_comb begin
      resp_valid = (state_q == S_RESP) || cwf_q;
      resp_data  = '0;
      if (resp_valid) resp_data = line_q[addr_q[OFF_W-1:2]*32 +: 32];
   end

endmodule

// File: tb/tb_fetch_line_responder.sv
// tb_fetch_line_responder: directed bench for fetch_line_responder. A hit table
// covers every word of a filled line; hand-written sequences cover misses,
// stalls, flushes and reset during a fill. Expected values are hand computed.
module tb_fetch_line_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        flush = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_word;
   } hit_vec_t;

   hit_vec_t    hit_tab[8];
   logic [63:0] beats[4];

   fetch_line_responder dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .flush      (flush),
      .mem_addr   (mem_addr),
      .mem_read   (mem_read),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Offer a request and return in the cycle after it is accepted.
   task automatic issue(input logic [31:0] addr, input logic with_flush);
      int n = 0;
      req_addr  = addr;
      req_valid = 1'b1;
      flush     = with_flush;
      while (req_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check("req_ready_timeout", {63'd0, req_ready}, 64'd1);
      step();
      req_valid = 1'b0;
      flush     = 1'b0;
   endtask

   // Serve a fill from beats[] starting in FILL_REQ; check the single response.
   task automatic fill(input logic [31:0] addr, input int stall, input logic flush_mid,
                       input logic junk_on_ready, input logic [31:0] exp_word);
      int          resp_cnt = 0;
      int          resp_at  = -1;
      int          exp_at;
      logic [31:0] resp_got = '0;
`ifdef CRITICAL_WORD_FIRST_EN
      exp_at = int'(addr[4:3]);
`else
      exp_at = 3;
`endif
      check("fill_mem_read", {63'd0, mem_read}, 64'd1);
      check("fill_mem_addr", {32'd0, mem_addr}, {32'd0, addr[31:5], 5'd0});
      for (int i = 0; i < stall; i++) begin
         step();
         check("stall_mem_read", {63'd0, mem_read}, 64'd1);
         check("stall_mem_addr", {32'd0, mem_addr}, {32'd0, addr[31:5], 5'd0});
         check("stall_req_ready", {63'd0, req_ready}, 64'd0);
      end
      mem_ready = 1'b1;
      if (junk_on_ready) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      step();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      check("fill_read_dropped", {63'd0, mem_read}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = beats[k];
         flush      = flush_mid && (k == 1);
         step();
         mem_rvalid = 1'b0;
         flush      = 1'b0;
         if (k < 3) check("fill_req_ready", {63'd0, req_ready}, 64'd0);
         if (resp_valid) begin
            resp_cnt++;
            resp_at  = k;
            resp_got = resp_data;
         end
      end
      step();
      if (resp_valid) resp_cnt++;
      check("resp_count", 64'(resp_cnt), 64'd1);
      check("resp_beat", 64'(resp_at), 64'(exp_at));
      check("resp_data", {32'd0, resp_got}, {32'd0, exp_word});
   endtask

   // Directed test sequence and final report.
   initial begin
      hit_tab[0] = '{32'h0000_1040, 32'h2222_0000};
      hit_tab[1] = '{32'h0000_1044, 32'h1111_0000};
      hit_tab[2] = '{32'h0000_1048, 32'h4444_0000};
      hit_tab[3] = '{32'h0000_104C, 32'h3333_0000};
      hit_tab[4] = '{32'h0000_1053, 32'h6666_0000};
      hit_tab[5] = '{32'h0000_1054, 32'h5555_0000};
      hit_tab[6] = '{32'h0000_1058, 32'h8888_0000};
      hit_tab[7] = '{32'h0000_105C, 32'h7777_0000};

      // Reset values.
      rst = 1'b1;
      step();
      step();
      check("rst_req_ready", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_data", {32'd0, resp_data}, 64'd0);
      check("rst_mem_read", {63'd0, mem_read}, 64'd0);
      check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      rst = 1'b0;
      step();
      check("ready_after_rst", {63'd0, req_ready}, 64'd1);

      // Cold miss with a five-cycle mem_ready stall.
      beats = '{64'h1111_0000_2222_0000, 64'h3333_0000_4444_0000,
                64'h5555_0000_6666_0000, 64'h7777_0000_8888_0000};
      issue(32'h0000_1044, 1'b0);
      fill(32'h0000_1044, 5, 1'b0, 1'b0, 32'h1111_0000);

      // Back-to-back hits on every word of the line.
      for (int i = 0; i < 8; i++) begin
         issue(hit_tab[i].addr, 1'b0);
         check("hit_valid", {63'd0, resp_valid}, 64'd1);
         check("hit_data", {32'd0, resp_data}, {32'd0, hit_tab[i].exp_word});
         check("hit_no_mem_read", {63'd0, mem_read}, 64'd0);
         step();
         check("hit_pulse_end", {63'd0, resp_valid}, 64'd0);
         check("hit_ready_again", {63'd0, req_ready}, 64'd1);
      end

      // Tag miss, with a stray beat in the mem_ready cycle; old line then misses.
      beats = '{64'hBBBB_0001_BBBB_0000, 64'hBBBB_0003_BBBB_0002,
                64'hBBBB_0005_BBBB_0004, 64'hBBBB_0007_BBBB_0006};
      issue(32'h0000_2000, 1'b0);
      fill(32'h0000_2000, 0, 1'b0, 1'b1, 32'hBBBB_0000);
      issue(32'h0000_1048, 1'b0);
      check("old_line_miss", {63'd0, mem_read}, 64'd1);
      beats = '{64'h1111_0000_2222_0000, 64'h3333_0000_4444_0000,
                64'h5555_0000_6666_0000, 64'h7777_0000_8888_0000};
      fill(32'h0000_1048, 0, 1'b0, 1'b0, 32'h4444_0000);

      // Flush in the same cycle as a request to the buffered line.
      issue(32'h0000_1050, 1'b1);
      check("flush_req_miss", {63'd0, mem_read}, 64'd1);
      fill(32'h0000_1050, 1, 1'b0, 1'b0, 32'h6666_0000);

      // Flush during a fill: response delivered, line then misses.
      beats = '{64'hCCCC_0001_CCCC_0000, 64'hCCCC_0003_CCCC_0002,
                64'hCCCC_0005_CCCC_0004, 64'hCCCC_0007_CCCC_0006};
      issue(32'h0000_3018, 1'b0);
      fill(32'h0000_3018, 0, 1'b1, 1'b0, 32'hCCCC_0006);
      issue(32'h0000_3018, 1'b0);
      check("post_flush_miss", {63'd0, mem_read}, 64'd1);
      fill(32'h0000_3018, 0, 1'b0, 1'b0, 32'hCCCC_0006);
      issue(32'h0000_301C, 1'b0);
      check("refill_hit_valid", {63'd0, resp_valid}, 64'd1);
      check("refill_hit_data", {32'd0, resp_data}, 64'h0000_0000_CCCC_0007);
      step();

      // Reset after two beats, then two stray beats.
      beats = '{64'h1111_0000_2222_0000, 64'h3333_0000_4444_0000,
                64'h5555_0000_6666_0000, 64'h7777_0000_8888_0000};
      issue(32'h0000_1044, 1'b0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = beats[k];
         step();
      end
      mem_rvalid = 1'b0;
      rst = 1'b1;
      step();
      check("midfill_rst_ready", {63'd0, req_ready}, 64'd0);
      rst = 1'b0;
      for (int k = 2; k < 4; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = beats[k];
         step();
         check("stray_no_resp", {63'd0, resp_valid}, 64'd0);
         check("stray_no_mem_read", {63'd0, mem_read}, 64'd0);
      end
      mem_rvalid = 1'b0;
      step();
      check("stray_idle_no_resp", {63'd0, resp_valid}, 64'd0);
      check("stray_idle_ready", {63'd0, req_ready}, 64'd1);
      issue(32'h0000_1044, 1'b0);
      check("after_rst_miss", {63'd0, mem_read}, 64'd1);
      fill(32'h0000_1044, 0, 1'b0, 1'b0, 32'h1111_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
